// File: rtl/osc_pkg.sv
// Shared types and default widths for the multi-waveform oscillator.
package osc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DIV_W_DEF  = 10;

  typedef enum logic [1:0] {
    SAW    = 2'b00,
    SQUARE = 2'b01,
    TRI    = 2'b10,
    OFF    = 2'b11
  } wave_sel_t;

endpackage

// File: rtl/osc_tick_gen.sv
// Programmable step divider: shadowed period limit, hard sync and one-cycle tick.
module osc_tick_gen
  import osc_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [DIV_W-1:0] divisor,
  input  logic [1:0]       oct_dwn,
  input  logic             sync,
  output logic             tick
);

  localparam int CNT_W = DIV_W + 3;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] limit_next;
  logic [DIV_W-1:0] div_eff;
  logic             at_limit;

  always_comb begin
    div_eff    = (divisor == '0) ? DIV_W'(1) : divisor;
    limit_next = {3'b000, div_eff} << oct_dwn;
  end

  assign at_limit = (count == limit_q);
  assign tick     = at_limit & ~sync;

  // count==0 only occurs right after reset or sync, so that is where the
  // first shadow load happens; later loads happen only on step boundaries.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count   <= '0;
      limit_q <= CNT_W'(1);
    end else if (sync) begin
      count   <= '0;
      limit_q <= limit_next;
    end else if (at_limit) begin
      count   <= CNT_W'(1);
      limit_q <= limit_next;
    end else if (count > limit_q) begin
      count <= CNT_W'(1);
    end else begin
      count <= count + CNT_W'(1);
      if (count == '0) begin
        limit_q <= limit_next;
      end
    end
  end

endmodule

// File: rtl/osc_multiwave.sv
// Multi-waveform oscillator: shared phase counter feeding a saw/square/triangle shaper.
module osc_multiwave
  import osc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              enable,
  input  logic [DIV_W-1:0]  divisor,
  input  logic [1:0]        oct_dwn,
  input  logic [1:0]        wave_sel,
  input  logic [DATA_W-1:0] pulse_w,
  input  logic              sync,
  output logic              tick,
  output logic [DATA_W-1:0] wave_out
);

  logic [DATA_W-1:0] phase;
  logic [DATA_W-1:0] shaped;
  logic [DATA_W-1:0] tri_v;
  wave_sel_t         sel;

  assign sel = wave_sel_t'(wave_sel);

  osc_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk     (clk),
    .nRst    (nRst),
    .divisor (divisor),
    .oct_dwn (oct_dwn),
    .sync    (sync),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      phase <= '0;
    end else if (sync) begin
      phase <= '0;
    end else if (tick) begin
      phase <= phase + DATA_W'(1);
    end
  end

  // Triangle folds the doubled phase on the way down via bitwise inversion.
  always_comb begin
    shaped = '0;
    tri_v  = phase << 1;
    case (sel)
      SAW:     shaped = phase;
      SQUARE:  shaped = (phase < pulse_w) ? '1 : '0;
      TRI:     shaped = phase[DATA_W-1] ? ~tri_v : tri_v;
      default: shaped = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wave_out <= '0;
    end else begin
      wave_out <= enable ? shaped : '0;
    end
  end

endmodule

// File: tb/tb_osc_multiwave.sv
// Directed self-checking bench for osc_multiwave with hand-computed expectations.
module tb_osc_multiwave;
  import osc_pkg::*;

  logic       clk = 1'b0;
  logic       nRst;
  logic       enable;
  logic [9:0] divisor;
  logic [1:0] oct_dwn;
  logic [1:0] wave_sel;
  logic [7:0] pulse_w;
  logic       sync;
  logic       tick;
  logic [7:0] wave_out;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  osc_multiwave dut (
    .clk      (clk),
    .nRst     (nRst),
    .enable   (enable),
    .divisor  (divisor),
    .oct_dwn  (oct_dwn),
    .wave_sel (wave_sel),
    .pulse_w  (pulse_w),
    .sync     (sync),
    .tick     (tick),
    .wave_out (wave_out)
  );

  always #5 clk = ~clk;

  // edge_n counts rising edges since the last reset release; sampling is on negedges.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      edge_n++;
    end
  endtask

  task automatic run_to(input int target);
    cyc(target - edge_n);
  endtask

  task automatic do_reset(input logic [9:0] div, input logic [1:0] oct);
    divisor = div;
    oct_dwn = oct;
    sync    = 1'b0;
    nRst    = 1'b0;
    @(negedge clk);
    nRst   = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset;
    divisor  = 10'd1;
    enable   = 1'b1;
    wave_sel = SAW;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tick !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_tick: got %0b expected 0", tick);
      end
      checks++;
      if (wave_out !== 8'h00) begin
        failures++;
        $display("[TB] FAIL reset_wave: got %0h expected 0", wave_out);
      end
    end
  endtask

  task automatic test_saw_div3;
    logic       exp_tick;
    logic [7:0] exp_wave;
    wave_sel = SAW;
    enable   = 1'b1;
    do_reset(10'd3, 2'd0);
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      exp_tick = (k % 3 == 0);
      exp_wave = (k < 2) ? 8'd0 : 8'((k - 2) / 3);
      checks++;
      if (tick !== exp_tick) begin
        failures++;
        $display("[TB] FAIL div3_tick@%0d: got %0b expected %0b", k, tick, exp_tick);
      end
      checks++;
      if (wave_out !== exp_wave) begin
        failures++;
        $display("[TB] FAIL div3_wave@%0d: got %0h expected %0h", k, wave_out, exp_wave);
      end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_wave;
    wave_sel = SAW;
    enable   = 1'b1;
    do_reset(10'd1, 2'd0);
    for (int k = 1; k <= 262; k++) begin
      cyc(1);
      exp_wave = (k < 2) ? 8'd0 : 8'(k - 2);
      checks++;
      if (wave_out !== exp_wave) begin
        failures++;
        $display("[TB] FAIL wrap_wave@%0d: got %0h expected %0h", k, wave_out, exp_wave);
      end
      checks++;
      if (tick !== 1'b1) begin
        failures++;
        $display("[TB] FAIL wrap_tick@%0d: got %0b expected 1", k, tick);
      end
    end
  endtask

  task automatic test_octave;
    logic exp_tick;
    do_reset(10'd3, 2'd2);
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      if (k == 6) divisor = 10'd5;
      exp_tick = (k == 12) || (k == 32);
      checks++;
      if (tick !== exp_tick) begin
        failures++;
        $display("[TB] FAIL octave_tick@%0d: got %0b expected %0b", k, tick, exp_tick);
      end
    end
  endtask

  task automatic test_sync;
    logic exp_tick;
    wave_sel = SAW;
    enable   = 1'b1;
    do_reset(10'd1, 2'd0);
    run_to(87);
    divisor = 10'd10;
    cyc(1);
    checks++;
    if (tick !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sync_pre_tick: got %0b expected 0", tick);
    end
    cyc(1);
    checks++;
    if (wave_out !== 8'h57) begin
      failures++;
      $display("[TB] FAIL sync_phase57: got %0h expected 57", wave_out);
    end
    run_to(92);
    sync = 1'b1;
    cyc(1);
    sync = 1'b0;
    #1;
    checks++;
    if (tick !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sync_after_tick: got %0b expected 0", tick);
    end
    for (int k = 94; k <= 104; k++) begin
      cyc(1);
      exp_tick = (k == 103);
      checks++;
      if (tick !== exp_tick) begin
        failures++;
        $display("[TB] FAIL sync_period_tick@%0d: got %0b expected %0b", k, tick, exp_tick);
      end
      if (k == 94) begin
        checks++;
        if (wave_out !== 8'h00) begin
          failures++;
          $display("[TB] FAIL sync_phase0: got %0h expected 0", wave_out);
        end
      end
    end
    cyc(1);
    checks++;
    if (wave_out !== 8'h01) begin
      failures++;
      $display("[TB] FAIL sync_phase1: got %0h expected 1", wave_out);
    end
    run_to(113);
    checks++;
    if (tick !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sync_limit_tick: got %0b expected 1", tick);
    end
    sync = 1'b1;
    #1;
    checks++;
    if (tick !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sync_suppress: got %0b expected 0", tick);
    end
    cyc(1);
    sync = 1'b0;
    cyc(1);
    checks++;
    if (wave_out !== 8'h00) begin
      failures++;
      $display("[TB] FAIL sync_priority_wave: got %0h expected 0", wave_out);
    end
  endtask

  task automatic test_shapes;
    wave_sel = TRI;
    enable   = 1'b1;
    pulse_w  = 8'h00;
    do_reset(10'd1, 2'd0);
    run_to(66);
    checks++;
    if (wave_out !== 8'h80) begin
      failures++;
      $display("[TB] FAIL tri_40: got %0h expected 80", wave_out);
    end
    run_to(129);
    checks++;
    if (wave_out !== 8'hFE) begin
      failures++;
      $display("[TB] FAIL tri_7f: got %0h expected fe", wave_out);
    end
    run_to(130);
    checks++;
    if (wave_out !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL tri_80: got %0h expected ff", wave_out);
    end
    run_to(194);
    checks++;
    if (wave_out !== 8'h7F) begin
      failures++;
      $display("[TB] FAIL tri_c0: got %0h expected 7f", wave_out);
    end
    run_to(257);
    checks++;
    if (wave_out !== 8'h01) begin
      failures++;
      $display("[TB] FAIL tri_ff: got %0h expected 01", wave_out);
    end

    wave_sel = SQUARE;
    pulse_w  = 8'h80;
    do_reset(10'd1, 2'd0);
    run_to(2);
    checks++;
    if (wave_out !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL sq_00: got %0h expected ff", wave_out);
    end
    run_to(129);
    checks++;
    if (wave_out !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL sq_7f: got %0h expected ff", wave_out);
    end
    run_to(130);
    checks++;
    if (wave_out !== 8'h00) begin
      failures++;
      $display("[TB] FAIL sq_80: got %0h expected 00", wave_out);
    end
    pulse_w = 8'h00;
    run_to(258);
    checks++;
    if (wave_out !== 8'h00) begin
      failures++;
      $display("[TB] FAIL sq_pw0: got %0h expected 00", wave_out);
    end
    wave_sel = SAW;
    cyc(1);
    checks++;
    if (wave_out !== 8'h01) begin
      failures++;
      $display("[TB] FAIL sel_saw: got %0h expected 01", wave_out);
    end
    wave_sel = OFF;
    cyc(1);
    checks++;
    if (wave_out !== 8'h00) begin
      failures++;
      $display("[TB] FAIL sel_off: got %0h expected 00", wave_out);
    end
  endtask

  task automatic test_enable_reset_div0;
    logic [7:0] exp_wave;
    wave_sel = SAW;
    enable   = 1'b1;
    do_reset(10'd1, 2'd0);
    run_to(10);
    checks++;
    if (wave_out !== 8'd8) begin
      failures++;
      $display("[TB] FAIL en_before: got %0h expected 8", wave_out);
    end
    enable = 1'b0;
    for (int k = 11; k <= 30; k++) begin
      cyc(1);
      checks++;
      if (wave_out !== 8'h00) begin
        failures++;
        $display("[TB] FAIL en_gated@%0d: got %0h expected 0", k, wave_out);
      end
    end
    enable = 1'b1;
    cyc(1);
    checks++;
    if (wave_out !== 8'd29) begin
      failures++;
      $display("[TB] FAIL en_resume: got %0h expected %0h", wave_out, 8'd29);
    end

    do_reset(10'd4, 2'd0);
    run_to(18);
    checks++;
    if (wave_out !== 8'd4) begin
      failures++;
      $display("[TB] FAIL div4_wave: got %0h expected 4", wave_out);
    end
    run_to(20);
    checks++;
    if (tick !== 1'b1) begin
      failures++;
      $display("[TB] FAIL div4_tick: got %0b expected 1", tick);
    end
    nRst = 1'b0;
    #1;
    checks++;
    if (tick !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_rst_tick: got %0b expected 0", tick);
    end
    checks++;
    if (wave_out !== 8'h00) begin
      failures++;
      $display("[TB] FAIL async_rst_wave: got %0h expected 0", wave_out);
    end

    do_reset(10'd0, 2'd0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      exp_wave = (k < 2) ? 8'd0 : 8'(k - 2);
      checks++;
      if (tick !== 1'b1) begin
        failures++;
        $display("[TB] FAIL div0_tick@%0d: got %0b expected 1", k, tick);
      end
      checks++;
      if (wave_out !== exp_wave) begin
        failures++;
        $display("[TB] FAIL div0_wave@%0d: got %0h expected %0h", k, wave_out, exp_wave);
      end
    end
  endtask

  initial begin
    nRst     = 1'b0;
    enable   = 1'b0;
    divisor  = '0;
    oct_dwn  = '0;
    wave_sel = SAW;
    pulse_w  = '0;
    sync     = 1'b0;

    test_reset();
    test_saw_div3();
    test_wrap();
    test_octave();
    test_sync();
    test_shapes();
    test_enable_reset_div0();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
